// File: rtl/isa_pkg.sv
// Symbolic ISA definitions shared by the instruction encoder and decoder:
// operation enum, opcode/subop constants and operand register ranges.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_AND  = 5'd0,
        OP_SLT  = 5'd1,
        OP_OR   = 5'd2,
        OP_BEQ  = 5'd3,
        OP_LW   = 5'd4,
        OP_SW   = 5'd5,
        OP_INC  = 5'd6,
        OP_NOT  = 5'd7,
        OP_ADD  = 5'd8,
        OP_ADDI = 5'd9,
        OP_SUB  = 5'd10,
        OP_TR   = 5'd11,
        OP_JR   = 5'd12,
        OP_SRL  = 5'd13,
        OP_SRA  = 5'd14,
        OP_SLL  = 5'd15,
        OP_HALT = 5'd16
    } op_e;

    // 3-bit major opcodes, word bits [8:6]
    localparam logic [2:0] OPC_ALU   = 3'b000;
    localparam logic [2:0] OPC_MEM   = 3'b001;
    localparam logic [2:0] OPC_ADD   = 3'b010;
    localparam logic [2:0] OPC_ADDI  = 3'b011;
    localparam logic [2:0] OPC_SUB   = 3'b100;
    localparam logic [2:0] OPC_TR    = 3'b101;
    localparam logic [2:0] OPC_JR    = 3'b110;
    localparam logic [2:0] OPC_SHIFT = 3'b111;

    // 2-bit subops, word bits [1:0] of the shared-opcode groups
    localparam logic [1:0] SUB_AND  = 2'b00;
    localparam logic [1:0] SUB_SLT  = 2'b01;
    localparam logic [1:0] SUB_OR   = 2'b10;
    localparam logic [1:0] SUB_BEQ  = 2'b11;
    localparam logic [1:0] SUB_LW   = 2'b00;
    localparam logic [1:0] SUB_SW   = 2'b01;
    localparam logic [1:0] SUB_INC  = 2'b10;
    localparam logic [1:0] SUB_NOT  = 2'b11;
    localparam logic [1:0] SUB_SRL  = 2'b00;
    localparam logic [1:0] SUB_SRA  = 2'b01;
    localparam logic [1:0] SUB_SLL  = 2'b10;
    localparam logic [1:0] SUB_HALT = 2'b11;

    // Register banks of four, selected by register number bits [3:2]
    localparam logic [1:0] BANK_R0_R3  = 2'b00;
    localparam logic [1:0] BANK_R4_R7  = 2'b01;
    localparam logic [1:0] BANK_R8_R11 = 2'b10;

    // TR uses offset windows that straddle banks
    localparam logic [3:0] TR_RD_LO = 4'd1;
    localparam logic [3:0] TR_RD_HI = 4'd8;
    localparam logic [3:0] TR_RS_LO = 4'd5;
    localparam logic [3:0] TR_RS_HI = 4'd12;

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction input and encoded-word output handshakes of the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [3:0]        in_rs;
    logic [3:0]        in_rt;
    logic [3:0]        in_rd;
    logic [5:0]        in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [8:0]        out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic instruction -> 9-bit machine word plus a
// legality flag covering both the op code and every operand range.
module instr_field_pack
    import isa_pkg::*;
(
    input  logic [4:0] op,
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    input  logic [3:0] rd,
    input  logic [5:0] imm,
    output logic [8:0] instr,
    output logic       legal
);
    logic [2:0] opcode;
    logic [1:0] subop;
    logic [5:0] field;
    logic       operands_ok;
    logic [2:0] tr_rd_off;
    logic [2:0] tr_rs_off;

    assign tr_rd_off = 3'(rd - TR_RD_LO);
    assign tr_rs_off = 3'(rs - TR_RS_LO);

    always_comb begin
        opcode = OPC_ALU;
        subop  = SUB_AND;
        case (op)
            OP_AND:  subop = SUB_AND;
            OP_SLT:  subop = SUB_SLT;
            OP_OR:   subop = SUB_OR;
            OP_BEQ:  subop = SUB_BEQ;
            OP_LW:   begin opcode = OPC_MEM;   subop = SUB_LW;   end
            OP_SW:   begin opcode = OPC_MEM;   subop = SUB_SW;   end
            OP_INC:  begin opcode = OPC_MEM;   subop = SUB_INC;  end
            OP_NOT:  begin opcode = OPC_MEM;   subop = SUB_NOT;  end
            OP_ADD:  opcode = OPC_ADD;
            OP_ADDI: opcode = OPC_ADDI;
            OP_SUB:  opcode = OPC_SUB;
            OP_TR:   opcode = OPC_TR;
            OP_JR:   opcode = OPC_JR;
            OP_SRL:  begin opcode = OPC_SHIFT; subop = SUB_SRL;  end
            OP_SRA:  begin opcode = OPC_SHIFT; subop = SUB_SRA;  end
            OP_SLL:  begin opcode = OPC_SHIFT; subop = SUB_SLL;  end
            OP_HALT: begin opcode = OPC_SHIFT; subop = SUB_HALT; end
            default: ;
        endcase
    end

    // Within a bank the bias subtraction (e.g. rs-4, rd-8) is just the low two bits.
    always_comb begin
        field       = '0;
        operands_ok = 1'b1;
        case (op)
            OP_AND, OP_SLT, OP_OR, OP_SW, OP_SRL, OP_SRA, OP_SLL: begin
                field       = {rs[1:0], rt[1:0], subop};
                operands_ok = (rs[3:2] == BANK_R4_R7) && (rt[3:2] == BANK_R0_R3);
            end
            OP_BEQ: begin
                field       = {rs[1:0], rt[1:0], subop};
                operands_ok = (rs[3:2] == BANK_R0_R3) && (rt[3:2] == BANK_R8_R11);
            end
            OP_LW: begin
                field       = {rs[1:0], rd[1:0], subop};
                operands_ok = (rs[3:2] == BANK_R4_R7) && (rd[3:2] == BANK_R0_R3);
            end
            OP_INC, OP_NOT: field = {rs, subop};
            OP_ADD, OP_SUB: begin
                field       = {rs[1:0], rt[1:0], rd[1:0]};
                operands_ok = (rs[3:2] == BANK_R4_R7) && (rt[3:2] == BANK_R0_R3)
                              && (rd[3:2] == BANK_R8_R11);
            end
            OP_ADDI: begin
                field       = {rd[1:0], rs[1:0], imm[1:0]};
                operands_ok = (rd[3:2] == BANK_R8_R11) && (rs[3:2] == BANK_R0_R3)
                              && (imm[5:2] == 4'b0000);
            end
            OP_TR: begin
                field       = {tr_rd_off, tr_rs_off};
                operands_ok = (rd >= TR_RD_LO) && (rd <= TR_RD_HI)
                              && (rs >= TR_RS_LO) && (rs <= TR_RS_HI);
            end
            OP_JR:   field = imm;
            OP_HALT: field = {4'b0000, subop};
            default: operands_ok = 1'b0;
        endcase
    end

    assign legal = operands_ok;
    assign instr = legal ? {opcode, field} : 9'd0;

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes a stream of symbolic instructions into machine
// words with sequential program addresses and sticky error reporting.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              out_valid_reg, out_valid_next;
    logic [8:0]        out_instr_reg, out_instr_next;
    logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic              err_reg, err_next;
    logic [ADDR_W-1:0] err_addr_reg, err_addr_next;

    logic [8:0] packed_instr;
    logic       packed_legal;
    logic       accept;

    instr_field_pack u_pack (
        .op    (bus.in_op),
        .rs    (bus.in_rs),
        .rt    (bus.in_rt),
        .rd    (bus.in_rd),
        .imm   (bus.in_imm),
        .instr (packed_instr),
        .legal (packed_legal)
    );

    assign bus.in_ready = (state_reg == ST_LOAD) && (!out_valid_reg || bus.out_ready);
    // start takes precedence over a simultaneous input transfer
    assign accept = bus.in_valid && bus.in_ready && !start;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        out_valid_next = out_valid_reg;
        out_instr_next = out_instr_reg;
        out_addr_next  = out_addr_reg;
        err_next       = err_reg;
        err_addr_next  = err_addr_reg;

        if (out_valid_reg && bus.out_ready) begin
            out_valid_next = 1'b0;
        end

        if (start) begin
            state_next    = ST_LOAD;
            addr_next     = '0;
            err_next      = 1'b0;
            err_addr_next = '0;
        end else if (accept) begin
            if (!packed_legal) begin
                err_next = 1'b1;
                if (!err_reg) err_addr_next = addr_reg;
            end else begin
                out_valid_next = 1'b1;
                out_instr_next = packed_instr;
                out_addr_next  = addr_reg;
                if (bus.in_op == OP_HALT) begin
                    state_next = ST_DONE;
                end else if (&addr_reg) begin
                    // program space exhausted without a HALT
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                    if (!err_reg) err_addr_next = addr_reg;
                end else begin
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_addr_reg  <= '0;
            err_reg       <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            out_valid_reg <= out_valid_next;
            out_instr_reg <= out_instr_next;
            out_addr_reg  <= out_addr_next;
            err_reg       <= err_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_instr = out_instr_reg;
    assign bus.out_addr  = out_addr_reg;
    assign done          = (state_reg == ST_DONE);
    assign err           = err_reg;
    assign err_addr      = err_addr_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_instr_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start2;
    logic       done1, err1, done2, err2;
    logic [7:0] err_addr1;
    logic [1:0] err_addr2;

    int checks = 0;
    int errors = 0;

    instr_encoder_if #(.ADDR_W(8)) bus1 ();
    instr_encoder_if #(.ADDR_W(2)) bus2 ();

    instr_encoder #(.ADDR_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bus(bus1),
        .done(done1), .err(err1), .err_addr(err_addr1)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(bus2),
        .done(done2), .err(err2), .err_addr(err_addr2)
    );

    always #5 clk = ~clk;

    // reference model state (transaction level)
    bit m_loading, m_done, m_err, m_ov;
    int m_addr, m_err_addr, m_instr, m_oaddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Encoding straight from the ISA tables, using plain arithmetic.
    function automatic void ref_encode(input int op, input int rs, input int rt, input int rd,
                                       input int imm, output int word, output bit ok);
        ok = 1'b1;
        word = 0;
        case (op)
            0, 1, 2: begin
                ok = rs >= 4 && rs <= 7 && rt <= 3;
                word = (rs - 4) * 16 + rt * 4 + op;
            end
            3: begin
                ok = rs <= 3 && rt >= 8 && rt <= 11;
                word = rs * 16 + (rt - 8) * 4 + 3;
            end
            4: begin
                ok = rs >= 4 && rs <= 7 && rd <= 3;
                word = 64 + (rs - 4) * 16 + rd * 4;
            end
            5: begin
                ok = rs >= 4 && rs <= 7 && rt <= 3;
                word = 64 + (rs - 4) * 16 + rt * 4 + 1;
            end
            6, 7: word = 64 + rs * 4 + (op - 4);
            8, 10: begin
                ok = rs >= 4 && rs <= 7 && rt <= 3 && rd >= 8 && rd <= 11;
                word = (op == 8 ? 128 : 256) + (rs - 4) * 16 + rt * 4 + (rd - 8);
            end
            9: begin
                ok = rd >= 8 && rd <= 11 && rs <= 3 && imm <= 3;
                word = 192 + (rd - 8) * 16 + rs * 4 + imm;
            end
            11: begin
                ok = rd >= 1 && rd <= 8 && rs >= 5 && rs <= 12;
                word = 320 + (rd - 1) * 8 + (rs - 5);
            end
            12: word = 384 + imm;
            13, 14, 15: begin
                ok = rs >= 4 && rs <= 7 && rt <= 3;
                word = 448 + (rs - 4) * 16 + rt * 4 + (op - 13);
            end
            16: word = 448 + 3;
            default: ok = 1'b0;
        endcase
    endfunction

    // Advance one clock: update the model from current inputs, then compare DUT1.
    task automatic tick();
        bit rdy, ok, n_loading, n_done, n_err, n_ov;
        int n_addr, n_err_addr, n_instr, n_oaddr, w;
        rdy = m_loading && (!m_ov || bus1.out_ready);
        n_loading = m_loading; n_done = m_done; n_err = m_err; n_ov = m_ov;
        n_addr = m_addr; n_err_addr = m_err_addr; n_instr = m_instr; n_oaddr = m_oaddr;
        if (reset) begin
            n_loading = 0; n_done = 0; n_err = 0; n_ov = 0;
            n_addr = 0; n_err_addr = 0; n_instr = 0; n_oaddr = 0;
        end else begin
            if (m_ov && bus1.out_ready) begin
                n_ov = 0;
                $display("xfer addr=%0d instr=%03h", m_oaddr, m_instr);
            end
            if (start1) begin
                n_loading = 1; n_done = 0; n_addr = 0; n_err = 0; n_err_addr = 0;
            end else if (bus1.in_valid && rdy) begin
                ref_encode(int'(bus1.in_op), int'(bus1.in_rs), int'(bus1.in_rt),
                           int'(bus1.in_rd), int'(bus1.in_imm), w, ok);
                if (!ok) begin
                    if (!m_err) n_err_addr = m_addr;
                    n_err = 1;
                end else begin
                    n_ov = 1; n_instr = w; n_oaddr = m_addr;
                    if (int'(bus1.in_op) == 16) begin
                        n_loading = 0; n_done = 1;
                    end else if (m_addr == 255) begin
                        if (!m_err) n_err_addr = m_addr;
                        n_err = 1; n_loading = 0; n_done = 1;
                    end else begin
                        n_addr = m_addr + 1;
                    end
                end
            end
        end
        @(posedge clk);
        m_loading = n_loading; m_done = n_done; m_err = n_err; m_ov = n_ov;
        m_addr = n_addr; m_err_addr = n_err_addr; m_instr = n_instr; m_oaddr = n_oaddr;
        @(negedge clk);
        check("in_ready", 32'(bus1.in_ready), 32'(m_loading && (!m_ov || bus1.out_ready)));
        check("out_valid", 32'(bus1.out_valid), 32'(m_ov));
        check("done", 32'(done1), 32'(m_done));
        check("err", 32'(err1), 32'(m_err));
        check("err_addr", 32'(err_addr1), 32'(m_err_addr));
        if (m_ov) begin
            check("out_instr", 32'(bus1.out_instr), 32'(m_instr));
            check("out_addr", 32'(bus1.out_addr), 32'(m_oaddr));
        end
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
        bus1.in_valid = 1'b1;
        bus1.in_op = 5'(op); bus1.in_rs = 4'(rs); bus1.in_rt = 4'(rt);
        bus1.in_rd = 4'(rd); bus1.in_imm = 6'(imm);
        tick();
        bus1.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    // Random word, biased toward legal operands by retrying against the model.
    task automatic rand_word();
        int o, rs, rt, rd, imm, w;
        bit ok, want;
        o = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
        want = ($urandom_range(0, 7) != 0);
        rs = 0; rt = 0; rd = 0; imm = 0;
        for (int t = 0; t < 300; t++) begin
            rs = $urandom_range(0, 15); rt = $urandom_range(0, 15); rd = $urandom_range(0, 15);
            imm = (o == 9) ? $urandom_range(0, 3) : $urandom_range(0, 63);
            ref_encode(o, rs, rt, rd, imm, w, ok);
            if (ok || !want) break;
        end
        bus1.in_op = 5'(o); bus1.in_rs = 4'(rs); bus1.in_rt = 4'(rt);
        bus1.in_rd = 4'(rd); bus1.in_imm = 6'(imm);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_op = '0; bus1.in_rs = '0; bus1.in_rt = '0;
        bus1.in_rd = '0; bus1.in_imm = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_rs = '0; bus2.in_rt = '0;
        bus2.in_rd = '0; bus2.in_imm = '0; bus2.out_ready = 1'b0;
        m_loading = 0; m_done = 0; m_err = 0; m_ov = 0;
        m_addr = 0; m_err_addr = 0; m_instr = 0; m_oaddr = 0;

        tick(); tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(bus1.out_valid), 0);
        check("rst_out_instr", 32'(bus1.out_instr), 0);
        check("rst_out_addr", 32'(bus1.out_addr), 0);
        check("rst_in_ready", 32'(bus1.in_ready), 0);
        check("rst_done", 32'(done1), 0);

        // first words, addresses 0..3
        pulse_start();
        bus1.out_ready = 1'b1;
        send(8, 5, 2, 9, 0);
        check("add_instr", 32'(bus1.out_instr), 32'h099);
        check("add_addr", 32'(bus1.out_addr), 0);
        send(10, 6, 1, 10, 0);
        check("sub_addr", 32'(bus1.out_addr), 1);
        send(6, 13, 0, 0, 0);
        send(7, 0, 0, 0, 0);
        // illegal operand at addr 4
        send(0, 2, 1, 0, 0);
        check("bad_valid", 32'(bus1.out_valid), 0);
        check("bad_err", 32'(err1), 1);
        check("bad_err_addr", 32'(err_addr1), 4);
        send(11, 7, 0, 3, 0);
        check("tr_instr", 32'(bus1.out_instr), 32'h152);
        check("tr_addr", 32'(bus1.out_addr), 4);

        // back-pressure for three cycles with a word pending
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_op = 5'd4; bus1.in_rs = 4'd5; bus1.in_rt = 4'd0;
        bus1.in_rd = 4'd2; bus1.in_imm = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", 32'(bus1.out_instr), 32'h152);
            check("stall_addr", 32'(bus1.out_addr), 4);
            check("stall_in_ready", 32'(bus1.in_ready), 0);
        end
        bus1.out_ready = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("lw_instr", 32'(bus1.out_instr), 32'h058);
        check("lw_addr", 32'(bus1.out_addr), 5);
        send(16, 0, 0, 0, 0);
        check("halt_instr", 32'(bus1.out_instr), 32'h1C3);
        check("halt_done", 32'(done1), 1);
        check("halt_in_ready", 32'(bus1.in_ready), 0);
        tick();

        // randomized traffic
        pulse_start();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            start1 = ($urandom_range(0, 59) == 0);
            bus1.in_valid = ($urandom_range(0, 9) < 7);
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            rand_word();
            tick();
        end
        reset = 1'b0; start1 = 1'b0; bus1.in_valid = 1'b0;

        // reset while a word is pending and err is set
        pulse_start();
        bus1.out_ready = 1'b1;
        send(20, 0, 0, 0, 0);
        bus1.out_ready = 1'b0;
        send(8, 4, 3, 11, 0);
        check("pend_valid", 32'(bus1.out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(bus1.out_valid), 0);
        check("mid_rst_instr", 32'(bus1.out_instr), 0);
        check("mid_rst_addr", 32'(bus1.out_addr), 0);
        check("mid_rst_err", 32'(err1), 0);
        check("mid_rst_err_addr", 32'(err_addr1), 0);
        check("mid_rst_done", 32'(done1), 0);
        check("mid_rst_in_ready", 32'(bus1.in_ready), 0);
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("idle_no_accept", 32'(bus1.out_valid), 0);

        // address overflow on the 2-bit instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        bus2.out_ready = 1'b1;
        bus2.in_valid = 1'b1; bus2.in_op = 5'd8; bus2.in_rs = 4'd4; bus2.in_rd = 4'd8;
        for (int i = 0; i < 4; i++) begin
            bus2.in_rt = 4'(i);
            tick();
            check("ovf_addr", 32'(bus2.out_addr), 32'(i));
            check("ovf_instr", 32'(bus2.out_instr), 32'(128 + 4 * i));
            check("ovf_valid", 32'(bus2.out_valid), 1);
            if (i < 3) begin
                check("ovf_early_err", 32'(err2), 0);
                check("ovf_early_done", 32'(done2), 0);
            end
        end
        bus2.in_valid = 1'b0;
        check("ovf_err", 32'(err2), 1);
        check("ovf_err_addr", 32'(err_addr2), 3);
        check("ovf_done", 32'(done2), 1);
        check("ovf_in_ready", 32'(bus2.in_ready), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, width of the program-memory write address.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a new program load at address 0.
REQ-005 in_valid / in_ready  input / output  1 / 1  symbolic-instruction handshake; transfer when both high on a clock edge.
REQ-006 in_op  input  5  operation code from isa_pkg: AND, SLT, OR, BEQ, LW, SW, INC, NOT, ADD, ADDI, SUB, TR, JR, SRL, SRA, SLL, HALT (values 0-16); 17-31 illegal.
REQ-007 in_rs, in_rt, in_rd  input  4 each  physical register numbers R0-R15.
REQ-008 in_imm  input  6  immediate; ADDI uses bits [1:0], JR uses all 6.
REQ-009 out_valid / out_ready  output / input  1 / 1  encoded-word handshake toward instruction-memory writer.
REQ-010 out_instr  output  9  encoded machine word; out_addr  output  ADDR_W  its program address.
REQ-011 done  output  1  load complete; err  output  1  sticky error; err_addr  output  ADDR_W  address of first error.

Function
REQ-012 States: IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE when HALT word is accepted into output register or address overflow occurs; DONE->LOAD on start; start in LOAD restarts at address 0, clearing err.
REQ-013 in_ready = (state==LOAD) && (!out_valid || out_ready).
REQ-014 Latency: legal word accepted at edge N appears on out_instr/out_addr with out_valid high after edge N; held stable while out_valid && !out_ready.
REQ-015 Encoding [8:6]/[5:0]: AND/SLT/OR/BEQ 000 with sub [1:0]=00/01/10/11; LW/SW/INC/NOT 001 sub 00/01/10/11; ADD 010; ADDI 011; SUB 100; TR 101; JR 110; SRL/SRA/SLL/HALT 111 sub 00/01/10/11.
REQ-016 Fields: AND/SLT/OR/SW/SRx: [5:4]=rs-4 (rs 4-7), [3:2]=rt (0-3); BEQ: [5:4]=rs (0-3), [3:2]=rt-8 (8-11); LW: [5:4]=rs-4, [3:2]=rd (0-3).
REQ-017 Fields: INC/NOT: [5:2]=rs (0-15); ADD/SUB: [5:4]=rs-4, [3:2]=rt, [1:0]=rd-8 (8-11); ADDI: [5:4]=rd-8, [3:2]=rs (0-3), [1:0]=imm (0-3).
REQ-018 Fields: TR: [5:3]=rd-1 (1-8), [2:0]=rs-5 (5-12); JR: [5:0]=imm; HALT: [5:2]=0000; unused fields of any op encode as 0.
REQ-019 Operand outside its range, or illegal in_op: handshake completes, no word emitted, address not advanced, err set, err_addr captured only if err was clear.
REQ-020 Address increments by 1 per emitted word; emitting a non-HALT word at address 2^ADDR_W-1 sets err (err_addr = that address) and enters DONE.
REQ-021 done high in DONE only; out_valid may still be high in DONE until the final word drains.
REQ-022 start and in_valid in same cycle: start wins, input not accepted.

Reset
REQ-023 reset: state=IDLE, out_valid=0, out_instr=0, out_addr=0, done=0, err=0, err_addr=0, in_ready=0.
REQ-024 reset mid-load discards the pending output word; reset has priority over start.

Structure
REQ-025 isa_pkg holds op enum, 3-bit opcode and 2-bit subop constants, register-range constants; shared with the decoder.
REQ-026 Combinational sub-module instr_field_pack: (op, rs, rt, rd, imm) -> (instr[8:0], legal); instr_encoder adds FSM, address counter, output register.

Verification
REQ-027 start; ADD rs=5 rt=2 rd=9 -> out_instr=0x099, out_addr=0, next word at addr 1.
REQ-028 TR rd=3 rs=7 -> 0x152; HALT -> 0x1C3, done=1 after accept, in_ready=0.
REQ-029 AND rs=2 at addr 4 -> no out_valid, err=1, err_addr=4; next legal word uses addr 4.
REQ-030 out_ready low 3 cycles with word pending -> out_instr/out_addr stable, in_ready=0, no loss/duplication.
REQ-031 ADDR_W=2, four legal non-HALT words -> fourth at addr 3, err=1, err_addr=3, done=1.
REQ-032 reset asserted with out_valid=1 mid-load -> next cycle all outputs at reset values, state IDLE.
